// File: rtl/figure_pkg.sv
// Shared constants and types for the figure motion sequencer: screen geometry, figure sizes,
// reset positions, sequencer state codes and the 11-bit coordinate type.
package figure_pkg;

    typedef logic [10:0] coord_t;

    localparam int H_RES = 640;
    localparam int V_RES = 480;
    localparam int STEP  = 4;
    localparam int SQ_W  = 125;
    localparam int SQ_H  = 125;
    localparam int RC_W  = 180;
    localparam int RC_H  = 125;

    localparam coord_t     STEP_C     = coord_t'(STEP);
    localparam logic [9:0] VBLANK_TOP = 10'(V_RES);

    // Largest legal top-left coordinate for each figure on each axis.
    localparam coord_t SQ_X_MAX = coord_t'(H_RES - SQ_W);
    localparam coord_t SQ_Y_MAX = coord_t'(V_RES - SQ_H);
    localparam coord_t RC_X_MAX = coord_t'(H_RES - RC_W);
    localparam coord_t RC_Y_MAX = coord_t'(V_RES - RC_H);

    localparam logic [9:0] SQ_X0 = 10'd255;
    localparam logic [9:0] SQ_Y0 = 10'd18;
    localparam logic [9:0] RC_X0 = 10'd230;
    localparam logic [9:0] RC_Y0 = 10'd178;

    localparam logic [1:0] ARMED = 2'd0;
    localparam logic [1:0] APPLY = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    typedef struct packed {
        logic sel;
        logic rt;
        logic lf;
        logic dn;
        logic up;
    } req_t;

endpackage

// File: rtl/fig_axis_step.sv
// One-axis position update: steps pos by STEP toward inc/dec and keeps it inside [0, limit].
// Define FIGURE_WRAP_EN to wrap around at the edges instead of clamping.
module fig_axis_step
    import figure_pkg::*;
(
    input  coord_t     pos,
    input  logic       inc,
    input  logic       dec,
    input  coord_t     limit,
    output logic [9:0] next
);

    coord_t up_pos;
    assign up_pos = pos + STEP_C;

    always_comb begin
        // NOTE: default assignment first so every path drives next and no latch is inferred.
        next = pos[9:0];
        if (inc && !dec) begin
            if (up_pos > limit) begin
`ifdef FIGURE_WRAP_EN
                next = '0;
`else
                next = limit[9:0];
`endif
            end else begin
                next = up_pos[9:0];
            end
        end else if (dec && !inc) begin
            if (pos < STEP_C) begin
`ifdef FIGURE_WRAP_EN
                next = limit[9:0];
`else
                next = '0;
`endif
            end else begin
                next = 10'(pos - STEP_C);
            end
        end
    end

endmodule

// File: rtl/figure_motion_ctrl.sv
// Moves the selected figure once per frame, at the first blanking line, from sticky button requests.
// Edge behaviour (clamp vs. wrap) follows FIGURE_WRAP_EN inside fig_axis_step.
module figure_motion_ctrl
    import figure_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] HCount,
    input  logic [9:0] VCount,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_sel,
    output logic       sel,
    output logic [9:0] sq_x,
    output logic [9:0] sq_y,
    output logic [9:0] rc_x,
    output logic [9:0] rc_y,
    output logic       frame_tick
);

    logic [1:0] state;
    req_t       pend;
    req_t       btn_now;
    logic       apply;
    logic [9:0] sq_x_nx, sq_y_nx, rc_x_nx, rc_y_nx;

    assign btn_now    = '{sel: btn_sel, rt: btn_right, lf: btn_left, dn: btn_down, up: btn_up};
    assign apply      = (state == APPLY);
    assign frame_tick = apply;

    // Only the currently selected figure sees the requests; sel is the pre-toggle value.
    fig_axis_step u_sq_x (.pos({1'b0, sq_x}), .inc(pend.rt & ~sel), .dec(pend.lf & ~sel),
                          .limit(SQ_X_MAX), .next(sq_x_nx));
    fig_axis_step u_sq_y (.pos({1'b0, sq_y}), .inc(pend.dn & ~sel), .dec(pend.up & ~sel),
                          .limit(SQ_Y_MAX), .next(sq_y_nx));
    fig_axis_step u_rc_x (.pos({1'b0, rc_x}), .inc(pend.rt & sel), .dec(pend.lf & sel),
                          .limit(RC_X_MAX), .next(rc_x_nx));
    fig_axis_step u_rc_y (.pos({1'b0, rc_y}), .inc(pend.dn & sel), .dec(pend.up & sel),
                          .limit(RC_Y_MAX), .next(rc_y_nx));

    // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARMED;
            pend  <= '0;
            sel   <= 1'b0;
            sq_x  <= SQ_X0;
            sq_y  <= SQ_Y0;
            rc_x  <= RC_X0;
            rc_y  <= RC_Y0;
        end else begin
            // Requests landing in the APPLY cycle survive into the next frame.
            pend <= apply ? btn_now : req_t'(pend | btn_now);

            case (state)
                ARMED:   if (HCount == '0 && VCount == VBLANK_TOP) state <= APPLY;
                APPLY:   state <= WAIT;
                WAIT:    if (VCount == '0) state <= ARMED;
                default: state <= ARMED;
            endcase

            if (apply) begin
                sq_x <= sq_x_nx;
                sq_y <= sq_y_nx;
                rc_x <= rc_x_nx;
                rc_y <= rc_y_nx;
                sel  <= sel ^ pend.sel;
            end
        end
    end

endmodule
